uart_tx_frame: RTL and testbench

Parametrised UART serial transmitter, the next generation of the team's fixed 8-bit transmitter. Runtime-selectable data length, parity mode and stop length, latched per frame. Serialises one word per accepted request onto `tx_out`, with a ready/start handshake that supports back-to-back frames. Sits between the baud-rate tick generator (`tick`, NUM_TICKS pulses per bit) and the board TX pin.

---
 rtl/uart_tx_frame_if.sv | 25 ++
 rtl/uart_tx_frame.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// Request/status bundle between a frame producer and the UART transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_MAX = 8
);
  logic                tx_start;
  logic [DATA_MAX-1:0] d_in;
  logic [3:0]          data_bits;
  logic [2:0]          parity_mode;
  logic [1:0]          stop_bits;
  logic                tx_ready;
  logic                tx_done;
  logic                tx_out;

  // Producer side: issues requests, watches handshake and line.
  modport master (
    output tx_start, d_in, data_bits, parity_mode, stop_bits,
    input  tx_ready, tx_done, tx_out
  );

  // Transmitter side.
  modport slave (
    input  tx_start, d_in, data_bits, parity_mode, stop_bits,
    output tx_ready, tx_done, tx_out
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter with per-frame data length, parity and stop length.
// Frame settings are captured into shadow registers on acceptance so the
// producer may change its inputs freely while a frame is on the line.
module uart_tx_frame #(
  parameter int NUM_TICKS = 16,
  parameter int DATA_MAX  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  uart_tx_frame_if.slave  bus
);
  localparam int SW = $clog2(NUM_TICKS * 2);
  localparam logic [SW-1:0] LAST_BIT  = SW'(NUM_TICKS - 1);
  localparam logic [SW-1:0] LAST_1P5  = SW'((NUM_TICKS * 3) / 2 - 1);
  localparam logic [SW-1:0] LAST_2    = SW'(NUM_TICKS * 2 - 1);
  localparam logic [3:0]    DMAX      = 4'(DATA_MAX);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       s_q, s_d;
  logic [3:0]          n_q, n_d;
  logic [DATA_MAX-1:0] shift_q, shift_d;
  logic [3:0]          nbits_q, nbits_d;
  logic                pen_q, pen_d;
  logic                par_q, par_d;
  logic [1:0]          stop_q, stop_d;
  logic                tx_q, tx_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;

  logic [3:0]          nbits_in;
  logic [DATA_MAX-1:0] masked;
  logic                pen_in;
  logic                par_in;
  logic [SW-1:0]       stop_last;

  // Clamp the requested data length into 5..DATA_MAX.
  always_comb begin
    nbits_in = bus.data_bits;
    if (bus.data_bits < 4'd5)
      nbits_in = 4'd5;
    else if (bus.data_bits > DMAX)
      nbits_in = DMAX;
  end

  // Only the bits that will actually be sent take part in parity.
  for (genvar gi = 0; gi < DATA_MAX; gi++) begin : g_mask
    assign masked[gi] = bus.d_in[gi] & (4'(gi) < nbits_in);
  end

  // Parity enable and parity bit for the request being presented.
  always_comb begin
    pen_in = 1'b0;
    par_in = 1'b0;
    case (bus.parity_mode)
      3'd1:    begin pen_in = 1'b1; par_in = ^masked;  end
      3'd2:    begin pen_in = 1'b1; par_in = ~^masked; end
      3'd3:    begin pen_in = 1'b1; par_in = 1'b1;     end
      3'd4:    begin pen_in = 1'b1; par_in = 1'b0;     end
      default: begin pen_in = 1'b0; par_in = 1'b0;     end
    endcase
  end

  // Final tick index of the stop period for the latched stop length.
  always_comb begin
    case (stop_q)
      2'd0:    stop_last = LAST_BIT;
      2'd1:    stop_last = LAST_1P5;
      default: stop_last = LAST_2;
    endcase
  end

  // Next-state and line value; the line is registered so it changes on
  // the edge that samples the last tick of each bit.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    nbits_d = nbits_q;
    pen_d   = pen_q;
    par_d   = par_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (ready_q && bus.tx_start) begin
          shift_d = bus.d_in;
          nbits_d = nbits_in;
          pen_d   = pen_in;
          par_d   = par_in;
          stop_d  = bus.stop_bits;
          s_d     = '0;
          n_d     = '0;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == LAST_BIT) begin
            s_d     = '0;
            n_d     = '0;
            tx_d    = shift_q[0];
            state_d = DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == LAST_BIT) begin
            s_d     = '0;
            shift_d = {1'b0, shift_q[DATA_MAX-1:1]};
            if (n_q == nbits_q - 4'd1) begin
              if (pen_q) begin
                tx_d    = par_q;
                state_d = PARITY;
              end else begin
                tx_d    = 1'b1;
                state_d = STOP;
              end
            end else begin
              n_d  = n_q + 4'd1;
              tx_d = shift_q[1];
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (s_q == LAST_BIT) begin
            s_d     = '0;
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (s_q == stop_last) begin
            s_d     = '0;
            done_d  = 1'b1;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        s_d     = '0;
        n_d     = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and shadow registers; reset forces the idle line at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      nbits_q <= '0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      stop_q  <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      nbits_q <= nbits_d;
      pen_q   <= pen_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx_out   = tx_q;
  assign bus.tx_ready = ready_q;
  assign bus.tx_done  = done_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: each frame is started, the line is
// sampled in the middle of every bit and the stop length is checked
// against the tick on which tx_done fires.
module tb_uart_tx_frame;
  logic clk;
  logic reset;
  logic tick;
  int   tests;
  int   fails;
  int   done_cnt;

  uart_tx_frame_if #(.DATA_MAX(8)) bus_if ();

  uart_tx_frame #(.NUM_TICKS(16), .DATA_MAX(8)) dut (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tick on every other clock, changed away from the rising edge.
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = ~tick;
    end
  end

  // Count tx_done pulses over the whole run.
  initial begin
    done_cnt = 0;
    forever begin
      @(posedge clk);
      if (bus_if.tx_done === 1'b1) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for n ticks sampled by the DUT, then step just past that edge.
  task automatic wait_ticks(input int n);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 4000) begin
      @(posedge clk);
      cyc++;
      if (tick) got++;
    end
    #1;
    if (got < n) begin
      tests++;
      fails++;
      $error("FAIL wait_ticks observed=%0d expected=%0d", got, n);
    end
  endtask

  task automatic start_frame(input string tag, input logic [7:0] d, input logic [3:0] db,
                             input logic [2:0] pm, input logic [1:0] sb, input bit hold);
    bus_if.d_in        = d;
    bus_if.data_bits   = db;
    bus_if.parity_mode = pm;
    bus_if.stop_bits   = sb;
    bus_if.tx_start    = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " accept_ready"}, 16'(bus_if.tx_ready), 16'd0);
    check({tag, " accept_out"},   16'(bus_if.tx_out),   16'd0);
    check({tag, " accept_done"},  16'(bus_if.tx_done),  16'd0);
    if (!hold) bus_if.tx_start = 1'b0;
  endtask

  // exp[k] is the line value of bit k (start bit is k=0), nb bits before stop.
  task automatic body_frame(input string tag, input logic [15:0] exp, input int nb,
                            input int stop_t, input bit b2b, input bit mutate);
    for (int k = 0; k < nb; k++) begin
      wait_ticks(k == 0 ? 8 : 16);
      check($sformatf("%s bit%0d", tag, k), 16'(bus_if.tx_out), 16'(exp[k]));
      check($sformatf("%s bit%0d_done", tag, k), 16'(bus_if.tx_done), 16'd0);
      if (mutate && k == 3) begin
        bus_if.parity_mode = 3'd2;
        bus_if.d_in        = 8'hFF;
        bus_if.tx_start    = 1'b1;
      end
      if (mutate && k == 5) begin
        check({tag, " busy_ready"}, 16'(bus_if.tx_ready), 16'd0);
        bus_if.tx_start = 1'b0;
      end
    end
    wait_ticks(12);
    check({tag, " stop"}, 16'(bus_if.tx_out), 16'd1);
    wait_ticks(stop_t - 5);
    check({tag, " pre_done"},  16'(bus_if.tx_done),  16'd0);
    check({tag, " pre_ready"}, 16'(bus_if.tx_ready), 16'd0);
    wait_ticks(1);
    check({tag, " done"},       16'(bus_if.tx_done),  16'd1);
    check({tag, " done_ready"}, 16'(bus_if.tx_ready), 16'd1);
    check({tag, " done_out"},   16'(bus_if.tx_out),   16'd1);
    if (!b2b) begin
      @(posedge clk);
      #1;
      check({tag, " post_done"},  16'(bus_if.tx_done),  16'd0);
      check({tag, " post_ready"}, 16'(bus_if.tx_ready), 16'd1);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus_if.tx_start    = 1'b0;
    bus_if.d_in        = 8'h00;
    bus_if.data_bits   = 4'd8;
    bus_if.parity_mode = 3'd0;
    bus_if.stop_bits   = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out",   16'(bus_if.tx_out),   16'd1);
    check("reset ready", 16'(bus_if.tx_ready), 16'd1);
    check("reset done",  16'(bus_if.tx_done),  16'd0);
    @(negedge clk);
    reset = 1'b1;

    // Frame cut short by reset in the middle of the data bits.
    start_frame("rst8N1", 8'h55, 4'd8, 3'd0, 2'd0, 1'b0);
    wait_ticks(8);
    check("rst8N1 bit0", 16'(bus_if.tx_out), 16'd0);
    wait_ticks(16);
    check("rst8N1 bit1", 16'(bus_if.tx_out), 16'd1);
    wait_ticks(16);
    check("rst8N1 bit2", 16'(bus_if.tx_out), 16'd0);
    reset = 1'b0;
    #2;
    check("midreset out",   16'(bus_if.tx_out),   16'd1);
    check("midreset ready", 16'(bus_if.tx_ready), 16'd1);
    check("midreset done",  16'(bus_if.tx_done),  16'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // 8N1 0x55: 0,1,0,1,0,1,0,1,0 then one stop bit.
    start_frame("8N1", 8'h55, 4'd8, 3'd0, 2'd0, 1'b0);
    body_frame("8N1", 16'h00AA, 9, 16, 1'b0, 1'b0);

    // 7E2 0xB5: 0,1,0,1,0,1,1,0, parity 0, two stop bits.
    start_frame("7E2", 8'hB5, 4'd7, 3'd1, 2'd2, 1'b0);
    body_frame("7E2", 16'h006A, 9, 32, 1'b0, 1'b0);

    // 5O1.5 0x01: 0,1,0,0,0,0, parity 0, 1.5 stop bits.
    start_frame("5O15", 8'h01, 4'd5, 3'd2, 2'd1, 1'b0);
    body_frame("5O15", 16'h0002, 7, 24, 1'b0, 1'b0);

    // Same frame with a too-short length request, clamped to 5.
    start_frame("2O15", 8'h01, 4'd2, 3'd2, 2'd1, 1'b0);
    body_frame("2O15", 16'h0002, 7, 24, 1'b0, 1'b0);

    // Back-to-back 8M1: 0xA5 then 0x3C, parity 1 in both.
    start_frame("b2bA5", 8'hA5, 4'd8, 3'd3, 2'd0, 1'b1);
    body_frame("b2bA5", 16'h034A, 10, 16, 1'b1, 1'b0);
    start_frame("b2b3C", 8'h3C, 4'd8, 3'd3, 2'd0, 1'b0);
    body_frame("b2b3C", 16'h0278, 10, 16, 1'b0, 1'b0);

    // Too-long length request clamped to 8, space parity, two stop bits.
    start_frame("15S2", 8'hC3, 4'd15, 3'd4, 2'd3, 1'b0);
    body_frame("15S2", 16'h0186, 10, 32, 1'b0, 1'b0);

    // Inputs changed mid-frame and a request while busy: frame stays 8N1 0x00.
    start_frame("mut", 8'h00, 4'd8, 3'd0, 2'd0, 1'b0);
    body_frame("mut", 16'h0000, 9, 16, 1'b0, 1'b1);
    wait_ticks(20);
    check("mut idle_ready", 16'(bus_if.tx_ready), 16'd1);
    check("mut idle_out",   16'(bus_if.tx_out),   16'd1);

    check("done pulses", 16'(done_cnt), 16'd8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
